// File: rtl/bcd_chain_counter.sv
// -----------------------------------------------------------------------------
// bcd_chain_counter
//
// Multi-digit BCD up/down counter with a built-in prescaler. The prescaler
// counts enabled clk cycles. Every PRESCALE-th enabled cycle is a step edge,
// and the chain of DIGITS decimal digits moves one count in the direction
// selected by up_dn. Synchronous clear and parallel load take precedence over
// counting. tick_out and wrap are registered pulses that line up with the
// cycle in which the new count value is first visible.
//
// Parameters:
//   DIGITS    number of BCD digits in the chain (>= 1)
//   PRESCALE  enabled clk cycles per count step (>= 1)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   en        count enable; prescaler and digits hold while low
//   up_dn     1 = count up, 0 = count down (sampled on step edges only)
//   clr       synchronous clear of count, prescaler and pulses
//   load      synchronous parallel load; digits above 9 are clamped to 9
//   load_val  BCD load value, digit 0 in [3:0]
//   count     current BCD value, digit 0 in [3:0]
//   tick_out  one-cycle pulse in the cycle a count step becomes visible
//   wrap      one-cycle pulse in the cycle a full-range wrap becomes visible
// -----------------------------------------------------------------------------
module bcd_chain_counter #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick_out,
    output logic                  wrap
);

    // A PRESCALE of 1 still gets a 1-bit register; it simply never leaves 0.
    localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     ps;
    logic                ps_done;

    logic [4*DIGITS-1:0] count_up;
    logic [4*DIGITS-1:0] count_dn;
    logic [4*DIGITS-1:0] load_clamped;
    logic                carry;
    logic                borrow;
    logic [3:0]          digit;
    logic [3:0]          ld_digit;

    assign ps_done = (ps == PS_LAST);

    // Next-value candidates for both directions plus the clamped load value.
    // carry/borrow ripple from digit 0 upward: a digit moves only if every
    // lower digit is at its rollover value (9 going up, 0 going down). Once
    // the loop finishes, carry says "all digits were 9" and borrow says "all
    // digits were 0", which are exactly the wrap conditions.
    // NOTE: every signal written here gets a default at the top of the block,
    // so no path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        count_up     = count;
        count_dn     = count;
        load_clamped = '0;
        carry        = 1'b1;
        borrow       = 1'b1;
        digit        = 4'd0;
        ld_digit     = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit = count[4*i +: 4];
            if (carry) begin
                count_up[4*i +: 4] = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
            end
            if (borrow) begin
                count_dn[4*i +: 4] = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
            end
            carry  = carry  & (digit == 4'd9);
            borrow = borrow & (digit == 4'd0);

            ld_digit = load_val[4*i +: 4];
            load_clamped[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
        end
    end

    // Priority: rst > clr > load > en. Pulses are cleared on every edge that
    // is not a step edge, which keeps them exactly one cycle wide.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            ps       <= '0;
            tick_out <= 1'b0;
            wrap     <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            ps       <= '0;
            tick_out <= 1'b0;
            wrap     <= 1'b0;
        end else if (load) begin
            count    <= load_clamped;
            ps       <= '0;
            tick_out <= 1'b0;
            wrap     <= 1'b0;
        end else if (!en) begin
            tick_out <= 1'b0;
            wrap     <= 1'b0;
        end else if (!ps_done) begin
            ps       <= ps + PS_W'(1);
            tick_out <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            ps       <= '0;
            tick_out <= 1'b1;
            if (up_dn) begin
                count <= count_up;
                wrap  <= carry;
            end else begin
                count <= count_dn;
                wrap  <= borrow;
            end
        end
    end

endmodule

// File: tb/tb_bcd_chain_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_chain_counter
//
// Three instances share one set of stimulus signals:
//   inst 0: DIGITS=4, PRESCALE=4
//   inst 1: DIGITS=4, PRESCALE=1
//   inst 2: DIGITS=1, PRESCALE=1000 (default)
// A behavioural model keeps each instance's value as a plain integer and
// steps it with modular arithmetic. On every driven cycle the model's
// expected outputs for all three instances go into a scoreboard queue, and
// they are popped and compared on the following falling edge. Scenario tasks
// also compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_bcd_chain_counter;

    typedef struct {
        int          inst;
        logic [17:0] exp;     // {count[15:0], tick_out, wrap}
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;

    logic [15:0] count_p4, count_p1;
    logic [3:0]  count_d;
    logic        tick_p4, tick_p1, tick_d;
    logic        wrap_p4, wrap_p1, wrap_d;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    int   m_val[3];
    int   m_ps[3];
    logic m_tick[3];
    logic m_wrap[3];

    always #5 clk = ~clk;

    bcd_chain_counter #(.DIGITS(4), .PRESCALE(4)) u_p4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count_p4), .tick_out(tick_p4), .wrap(wrap_p4)
    );

    bcd_chain_counter #(.DIGITS(4), .PRESCALE(1)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .count(count_p1), .tick_out(tick_p1), .wrap(wrap_p1)
    );

    bcd_chain_counter #(.DIGITS(1)) u_def (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .count(count_d), .tick_out(tick_d), .wrap(wrap_d)
    );

    // ---------------- model ----------------
    function automatic int pow10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int digits_of(input int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int prescale_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 1000;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input int d);
        logic [15:0] r = '0;
        for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [17:0] dut_obs(input int k);
        case (k)
            0:       return {count_p4, tick_p4, wrap_p4};
            1:       return {count_p1, tick_p1, wrap_p1};
            default: return {12'h000, count_d, tick_d, wrap_d};
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_val[k] = 0; m_ps[k] = 0; m_tick[k] = 1'b0; m_wrap[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic e, input logic u, input logic c,
                              input logic l, input logic [15:0] lv);
        for (int k = 0; k < 3; k++) begin
            int d   = digits_of(k);
            int mod = pow10(d);
            m_tick[k] = 1'b0;
            m_wrap[k] = 1'b0;
            if (c) begin
                m_val[k] = 0; m_ps[k] = 0;
            end else if (l) begin
                m_val[k] = 0;
                for (int i = 0; i < d; i++) begin
                    int dg = int'(lv[4*i +: 4]);
                    if (dg > 9) dg = 9;
                    m_val[k] += dg * pow10(i);
                end
                m_ps[k] = 0;
            end else if (e) begin
                if (m_ps[k] != prescale_of(k) - 1) begin
                    m_ps[k]++;
                end else begin
                    m_ps[k]   = 0;
                    m_tick[k] = 1'b1;
                    if (u) begin
                        m_wrap[k] = (m_val[k] == mod - 1);
                        m_val[k]  = (m_val[k] + 1) % mod;
                    end else begin
                        m_wrap[k] = (m_val[k] == 0);
                        m_val[k]  = (m_val[k] + mod - 1) % mod;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of stimulus (called at a falling edge), push the
    // expected outputs, let the rising edge happen, then score on the next
    // falling edge.
    task automatic cycle(input string name, input logic e, input logic u,
                         input logic c, input logic l, input logic [15:0] lv);
        exp_t x;
        en = e; up_dn = u; clr = c; load = l; load_val = lv;
        model_edge(e, u, c, l, lv);
        for (int k = 0; k < 3; k++) begin
            x.inst = k;
            x.exp  = {to_bcd(m_val[k], digits_of(k)), m_tick[k], m_wrap[k]};
            x.name = name;
            sb.push_back(x);
        end
        @(posedge clk);
        @(negedge clk);
        while (sb.size() > 0) begin
            logic [17:0] obs;
            x   = sb.pop_front();
            obs = dut_obs(x.inst);
            checks++;
            if (obs !== x.exp) begin
                errors++;
                $display("FAIL %s inst%0d: got count=%h tick=%b wrap=%b, expected count=%h tick=%b wrap=%b",
                         x.name, x.inst, obs[17:2], obs[1], obs[0], x.exp[17:2], x.exp[1], x.exp[0]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            logic [17:0] obs = dut_obs(k);
            checks++;
            if (obs !== 18'h0) begin
                errors++;
                $display("FAIL reset_state inst%0d: got %h, expected 0", k, obs);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset_mid();
        cycle("rm_load", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0123);
        cycle("rm_run", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle("rm_run", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if (count_p4 !== 16'h0123) begin
            errors++;
            $display("FAIL rm_precount: got %h, expected 0123", count_p4);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            logic [17:0] obs = dut_obs(k);
            checks++;
            if (obs !== 18'h0) begin
                errors++;
                $display("FAIL rm_async inst%0d: got %h, expected 0", k, obs);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({count_p4, tick_p4, wrap_p4} !== 18'h0) begin
            errors++;
            $display("FAIL rm_hold: got %h/%b/%b, expected 0000/0/0", count_p4, tick_p4, wrap_p4);
        end
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle("rm_after", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            checks++;
            if (tick_p4 !== (i == 4)) begin
                errors++;
                $display("FAIL rm_first_tick edge%0d: got tick=%b, expected %b", i, tick_p4, (i == 4));
            end
        end
    endtask

    task automatic test_default_decade();
        int ticks = 0;
        int wraps = 0;
        cycle("dd_clr", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 1; i <= 10000; i++) begin
            cycle("dd_run", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            if (tick_d) ticks++;
            if (wrap_d) wraps++;
            if (i == 10000) begin
                checks++;
                if ({count_d, tick_d, wrap_d} !== {4'd0, 1'b1, 1'b1}) begin
                    errors++;
                    $display("FAIL dd_final_wrap: got %h/%b/%b, expected 0/1/1", count_d, tick_d, wrap_d);
                end
            end
        end
        checks++;
        if (ticks !== 10) begin
            errors++;
            $display("FAIL dd_tick_count: got %0d, expected 10", ticks);
        end
        checks++;
        if (wraps !== 1) begin
            errors++;
            $display("FAIL dd_wrap_count: got %0d, expected 1", wraps);
        end
    endtask

    task automatic test_carry_up();
        cycle("cu_load0999", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0999);
        cycle("cu_step", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({count_p1, tick_p1, wrap_p1} !== {16'h1000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL cu_0999_up: got %h/%b/%b, expected 1000/1/0", count_p1, tick_p1, wrap_p1);
        end
        cycle("cu_load9999", 1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
        cycle("cu_wrap", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({count_p1, tick_p1, wrap_p1} !== {16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL cu_9999_up: got %h/%b/%b, expected 0000/1/1", count_p1, tick_p1, wrap_p1);
        end
        cycle("cu_idle", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({tick_p1, wrap_p1} !== 2'b00) begin
            errors++;
            $display("FAIL cu_pulse_width: got tick=%b wrap=%b, expected 0/0", tick_p1, wrap_p1);
        end
    endtask

    task automatic test_down();
        logic [15:0] want[3] = '{16'h0501, 16'h0500, 16'h0501};
        cycle("dn_load1000", 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
        cycle("dn_step", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({count_p1, wrap_p1} !== {16'h0999, 1'b0}) begin
            errors++;
            $display("FAIL dn_1000_down: got %h/%b, expected 0999/0", count_p1, wrap_p1);
        end
        cycle("dn_load0000", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        cycle("dn_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({count_p1, tick_p1, wrap_p1} !== {16'h9999, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL dn_0000_down: got %h/%b/%b, expected 9999/1/1", count_p1, tick_p1, wrap_p1);
        end
        cycle("dn_load0500", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0500);
        for (int i = 0; i < 3; i++) begin
            cycle("dn_toggle", 1'b1, (i != 1), 1'b0, 1'b0, 16'h0);
            checks++;
            if (count_p1 !== want[i]) begin
                errors++;
                $display("FAIL dn_toggle step%0d: got %h, expected %h", i, count_p1, want[i]);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic pat[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int ticks = 0;
        cycle("eg_clr", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 9; i++) begin
            cycle("eg_run", pat[i], 1'b1, 1'b0, 1'b0, 16'h0);
            if (tick_p4) ticks++;
            if (i < 8) begin
                checks++;
                if (count_p4 !== 16'h0000) begin
                    errors++;
                    $display("FAIL eg_hold cyc%0d: got %h, expected 0000", i, count_p4);
                end
            end
        end
        checks++;
        if ({count_p4, tick_p4} !== {16'h0001, 1'b1}) begin
            errors++;
            $display("FAIL eg_step: got %h/%b, expected 0001/1", count_p4, tick_p4);
        end
        checks++;
        if (ticks !== 1) begin
            errors++;
            $display("FAIL eg_tick_count: got %0d, expected 1", ticks);
        end
    endtask

    task automatic test_priority();
        cycle("pr_clamp", 1'b0, 1'b1, 1'b0, 1'b1, 16'hF3A2);
        checks++;
        if ({count_p4, count_p1} !== {16'h9392, 16'h9392}) begin
            errors++;
            $display("FAIL pr_clamp: got %h,%h, expected 9392,9392", count_p4, count_p1);
        end
        // Prescaler cleared by load: the step lands on the 4th enabled edge.
        for (int i = 1; i <= 4; i++) cycle("pr_ps_zero", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        checks++;
        if ({count_p4, tick_p4} !== {16'h9393, 1'b1}) begin
            errors++;
            $display("FAIL pr_ps_zero: got %h/%b, expected 9393/1", count_p4, tick_p4);
        end
        cycle("pr_clr_load", 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        checks++;
        if ({count_p4, count_p1} !== 32'h0) begin
            errors++;
            $display("FAIL pr_clr_over_load: got %h,%h, expected 0000,0000", count_p4, count_p1);
        end
        for (int i = 0; i < 3; i++) cycle("pr_prerun", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        cycle("pr_load_step", 1'b1, 1'b1, 1'b0, 1'b1, 16'h0042);
        checks++;
        if ({count_p4, tick_p4, wrap_p4} !== {16'h0042, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL pr_load_over_step: got %h/%b/%b, expected 0042/0/0", count_p4, tick_p4, wrap_p4);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            logic e = ($urandom_range(0, 3) != 0);
            logic u = $urandom_range(0, 1) == 1;
            logic c = ($urandom_range(0, 47) == 0);
            logic l = ($urandom_range(0, 15) == 0);
            logic [15:0] lv = 16'($urandom);
            cycle("b2b_random", e, u, c, l, lv);
        end
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        test_reset_mid();
        test_default_decade();
        test_carry_up();
        test_down();
        test_enable_gating();
        test_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
